// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide RAM with combinational read and synchronous write.
// Sub-word stores become read-modify-write; illegal accesses are rejected before touching memory.
module lsu_mem_master #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, RMW, WRITE, RESP} state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        access_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    assign mem_addr = {lat_addr[31:2], 2'b00};

    always_comb begin
        access_err = 1'b0;
        case (lat_f3)
            3'b000:  access_err = 1'b0;
            3'b001:  access_err = lat_addr[0];
            3'b010:  access_err = |lat_addr[1:0];
            3'b100:  access_err = lat_we;
            3'b101:  access_err = lat_we | lat_addr[0];
            default: access_err = 1'b1;
        endcase
        if (lat_addr[31:2] >= 30'(MEM_WORDS))
            access_err = 1'b1;
    end

    // Little-endian lane pick, then sign/zero extension by funct3
    always_comb begin
        ld_byte = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
        ld_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (lat_f3[0])
            merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
        else
            merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= 32'd0;
            lat_we     <= 1'b0;
            lat_f3     <= 3'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            mem_wr_en  <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    lat_we    <= req_we;
                    lat_f3    <= req_funct3;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                    req_ready <= 1'b0;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (access_err) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (!lat_we) begin
                        state <= LOAD;
                    end else if (lat_f3 == 3'b010) begin
                        mem_wr_en <= 1'b1;
                        mem_wdata <= lat_wdata;
                        state     <= WRITE;
                    end else begin
                        state <= RMW;
                    end
                end
                LOAD: begin
                    resp_rdata <= ld_ext;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW: begin
                    mem_wr_en <= 1'b1;
                    mem_wdata <= merged;
                    state     <= WRITE;
                end
                WRITE: begin
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, reset-abort and back-to-back sequences,
// then random accesses scored against a byte-level memory model.
module tb_lsu_mem_master;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        do_preload = 1'b1;
    int          wr_cnt = 0;
    int          passed = 0;
    int          total = 0;

    lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 62) return 32'h87654321;
        if (i == 63) return 32'hF0F0F0F0;
        return 32'(100 + i);
    endfunction

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_word(i);
        end else if (mem_wr_en) begin
            ram[mem_addr[7:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: byte-granular view of memory with RISC-V access rules
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd,
                              output logic err, output int lat, output int nwr);
        int size, sh, idx;
        logic [31:0] v, mask;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        sh   = 8 * int'(addr[1:0]);
        err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
        if ((addr % size) != 0) err = 1'b1;
        if (addr[31:2] >= MEM_WORDS) err = 1'b1;
        rd = 32'd0; nwr = 0;
        if (err) begin
            lat = 2;
        end else begin
            idx = int'(addr[31:2]);
            if (!we) begin
                v = ref_mem[idx] >> sh;
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
                end
                rd = v; lat = 3;
            end else begin
                mask = (size == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * size)) - 1) << sh);
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
                nwr = 1;
                lat = (size == 4) ? 3 : 4;
            end
        end
    endtask

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rd,
                             output logic err, output int lat, output int nwr);
        int g, w0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        w0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b1; req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 12) begin @(negedge clk); lat++; end
        rd = resp_rdata; err = resp_err; nwr = wr_cnt - w0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                       input int lat, input int nwr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.nwr = nwr;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        err, eerr;
        int          lat, elat, nwr, enwr, cnt;
        logic [2:0]  f3s [7];
        logic [31:0] q[$];
        logic [31:0] exp_q[$];

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        do_preload = 1'b0;
        reset_n = 1'b1;

        add(0, 3'b000, 32'hF8, 0, 32'h00000021, 0, 3, 0);
        add(0, 3'b000, 32'hFB, 0, 32'hFFFFFF87, 0, 3, 0);
        add(0, 3'b100, 32'hFB, 0, 32'h00000087, 0, 3, 0);
        add(0, 3'b001, 32'hFA, 0, 32'hFFFF8765, 0, 3, 0);
        add(0, 3'b101, 32'hF8, 0, 32'h00004321, 0, 3, 0);
        add(0, 3'b001, 32'hFE, 0, 32'hFFFFF0F0, 0, 3, 0);
        add(0, 3'b101, 32'hFC, 0, 32'h0000F0F0, 0, 3, 0);
        add(0, 3'b010, 32'hFC, 0, 32'hF0F0F0F0, 0, 3, 0);
        add(1, 3'b000, 32'h0D, 32'h123456AB, 32'h0, 0, 4, 1);
        add(0, 3'b010, 32'h0C, 0, 32'h0000AB67, 0, 3, 0);
        add(1, 3'b001, 32'h12, 32'h5555BEEF, 32'h0, 0, 4, 1);
        add(0, 3'b010, 32'h10, 0, 32'hBEEF0068, 0, 3, 0);
        add(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 3, 1);
        add(0, 3'b010, 32'h20, 0, 32'hCAFEF00D, 0, 3, 0);
        add(1, 3'b010, 32'h06, 32'hFFFFFFFF, 32'h0, 1, 2, 0);
        add(0, 3'b001, 32'hF9, 0, 32'h0, 1, 2, 0);
        add(0, 3'b010, 32'h100, 0, 32'h0, 1, 2, 0);
        add(0, 3'b011, 32'h00, 0, 32'h0, 1, 2, 0);
        add(1, 3'b100, 32'h00, 32'h12345678, 32'h0, 1, 2, 0);
        add(0, 3'b000, 32'h00, 0, 32'h00000064, 0, 3, 0);

        foreach (tbl[i]) begin
            do_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, err, lat, nwr);
            ref_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, erd, eerr, elat, enwr);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_wr", i), 32'(nwr), 32'(tbl[i].nwr));
        end

        // Reset during WRITE: the write must not land and no response may follow
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_wr_en_before", 32'(mem_wr_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_wr_en_drop", 32'(mem_wr_en), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (resp_valid) cnt++; end
        chk("abort_no_resp", 32'(cnt), 32'd0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_ram_kept", ram[8], ref_mem[8]);

        // Four loads with req_valid held high
        ref_access(0, 3'b010, 32'hF8, 0, erd, eerr, elat, enwr); exp_q.push_back(erd);
        ref_access(0, 3'b000, 32'hFB, 0, erd, eerr, elat, enwr); exp_q.push_back(erd);
        ref_access(0, 3'b101, 32'h12, 0, erd, eerr, elat, enwr); exp_q.push_back(erd);
        ref_access(0, 3'b010, 32'h0C, 0, erd, eerr, elat, enwr); exp_q.push_back(erd);
        fork
            begin
                logic [2:0]  bf3 [4];
                logic [31:0] bad [4];
                int g;
                bf3[0] = 3'b010; bf3[1] = 3'b000; bf3[2] = 3'b101; bf3[3] = 3'b010;
                bad[0] = 32'hF8; bad[1] = 32'hFB; bad[2] = 32'h12; bad[3] = 32'h0C;
                @(negedge clk);
                req_valid = 1'b1; req_we = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    req_funct3 = bf3[i]; req_addr = bad[i];
                    g = 0;
                    while (!req_ready && g < 20) begin @(negedge clk); g++; end
                    @(posedge clk);
                    @(negedge clk);
                end
                req_valid = 1'b0;
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (resp_valid) q.push_back(resp_rdata);
                end
            end
        join
        chk("b2b_count", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_rdata%0d", i), (i < q.size()) ? q[i] : 32'hXXXXXXXX, exp_q[i]);

        // Random accesses against the reference model
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100;
        f3s[4] = 3'b101; f3s[5] = 3'b011; f3s[6] = 3'b110;
        for (int i = 0; i < 80; i++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] raddr, rwd;
            rwe   = 1'($urandom_range(0, 1));
            rf3   = f3s[($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 6)];
            raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
            rwd   = $urandom;
            do_access(rwe, rf3, raddr, rwd, rd, err, lat, nwr);
            ref_access(rwe, rf3, raddr, rwd, erd, eerr, elat, enwr);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_wr", i), 32'(nwr), 32'(enwr));
        end

        @(negedge clk);
        for (int i = 0; i < MEM_WORDS; i++)
            chk($sformatf("ram%0d", i), ram[i], ref_mem[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
